alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/lc3_alu_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/alu_arbiter.sv | 123 ++++++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_alu_pkg.sv
// Shared LC-3 ALU types: ALUK opcode, condition codes and arbiter FSM states.
// Condition-code helper is used by the arbiter and by any ALU model.
package lc3_alu_pkg;

    typedef enum logic [1:0] {
        ADD    = 2'b00,
        AND_   = 2'b01,
        NOT_   = 2'b10,
        PASS_A = 2'b11
    } aluk_t;

    typedef struct packed {
        logic n;
        logic z;
        logic p;
    } nzp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    function automatic nzp_t calc_nzp(input logic [15:0] d);
        nzp_t r;
        r.n = d[15];
        r.z = (d == 16'h0000);
        r.p = ~d[15] & (d != 16'h0000);
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant, search starts after last_i.
// No internal state; grant is forced to zero when en_i is low.
module rr_arbiter
    import lc3_alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      idx_o
);

    int   cand;
    logic found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_i) + off) % NUM_REQ;
            if (en_i && !found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external LC-3 ALU among NUM_REQ requesters; result valid two cycles after accept.
// One operation in flight; no new accepts until the response handshake completes.
module alu_arbiter
    import lc3_alu_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0][1:0]   req_aluk,
    input  logic [NUM_REQ-1:0][15:0]  req_a,
    input  logic [NUM_REQ-1:0][15:0]  req_b,
    output logic [NUM_REQ-1:0]        rsp_valid,
    input  logic [NUM_REQ-1:0]        rsp_ready,
    output logic [15:0]               rsp_data,
    output logic [2:0]                rsp_nzp,
    output logic [1:0]                ALUK,
    output logic [15:0]               RegFile_Out,
    output logic [15:0]               SR2MUX_Out,
    input  logic [15:0]               ToBus,
    output logic                      busy,
    output logic [15:0]               op_count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_q, last_d;
    aluk_t           aluk_q, aluk_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     b_q, b_d;
    logic [15:0]     data_q, data_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_en;

    assign arb_en = (state_q == IDLE);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req_i  (req_valid),
        .last_i (last_q),
        .en_i   (arb_en),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        aluk_d    = aluk_q;
        a_d       = a_q;
        b_d       = b_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        rsp_valid = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = arb_gnt;
                    grant_d   = arb_idx;
                    aluk_d    = aluk_t'(req_aluk[arb_idx]);
                    a_d       = req_a[arb_idx];
                    b_d       = req_b[arb_idx];
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                data_d  = ToBus;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    cnt_d   = cnt_q + 16'd1;
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to the top index so the first search begins at requester 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            aluk_q  <= ADD;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            aluk_q  <= aluk_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ALUK        = aluk_q;
    assign RegFile_Out = a_q;
    assign SR2MUX_Out  = b_q;
    assign rsp_data    = data_q;
    assign rsp_nzp     = calc_nzp(data_q);
    assign busy        = (state_q != IDLE);
    assign op_count    = cnt_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural LC-3 ALU closing the ToBus loop.
module tb_alu_arbiter;
    import lc3_alu_pkg::*;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][1:0]   req_aluk;
    logic [1:0][15:0]  req_a;
    logic [1:0][15:0]  req_b;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [15:0]       rsp_data;
    logic [2:0]        rsp_nzp;
    logic [1:0]        ALUK;
    logic [15:0]       RegFile_Out;
    logic [15:0]       SR2MUX_Out;
    logic [15:0]       ToBus;
    logic              busy;
    logic [15:0]       op_count;

    int checks;
    int failures;

    alu_arbiter #(.NUM_REQ(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_aluk    (req_aluk),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_nzp     (rsp_nzp),
        .ALUK        (ALUK),
        .RegFile_Out (RegFile_Out),
        .SR2MUX_Out  (SR2MUX_Out),
        .ToBus       (ToBus),
        .busy        (busy),
        .op_count    (op_count)
    );

    always_comb begin
        ToBus = 16'h0000;
        case (ALUK)
            2'b00:   ToBus = RegFile_Out + SR2MUX_Out;
            2'b01:   ToBus = RegFile_Out & SR2MUX_Out;
            2'b10:   ToBus = ~RegFile_Out;
            default: ToBus = RegFile_Out;
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with the FSM in IDLE; returns the same way.
    task automatic do_op(input int r, input logic [1:0] k, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp_d,
                         input logic [2:0] exp_nzp, input logic [15:0] exp_cnt,
                         input string tag);
        logic [1:0] oh;
        oh = 2'b00;
        oh[r] = 1'b1;
        req_valid   = oh;
        req_aluk[r] = k;
        req_a[r]    = a;
        req_b[r]    = b;
        rsp_ready   = 2'b00;
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(oh));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk({tag, "_aluk"}, 32'(ALUK), 32'(k));
        chk({tag, "_opa"}, 32'(RegFile_Out), 32'(a));
        chk({tag, "_opb"}, 32'(SR2MUX_Out), 32'(b));
        chk({tag, "_nvld_t1"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        @(posedge clk); @(negedge clk);
        #1;
        chk({tag, "_vld_t2"}, 32'(rsp_valid), 32'(oh));
        chk({tag, "_data"}, 32'(rsp_data), 32'(exp_d));
        chk({tag, "_nzp"}, 32'(rsp_nzp), 32'(exp_nzp));
        rsp_ready[r] = 1'b1;
        @(posedge clk); @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk({tag, "_vld_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
        chk({tag, "_hold_aluk"}, 32'(ALUK), 32'(k));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rvld"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_data"}, 32'(rsp_data), 32'h0000);
        chk({tag, "_nzp"}, 32'(rsp_nzp), 32'b010);
        chk({tag, "_aluk"}, 32'(ALUK), 32'd0);
        chk({tag, "_opa"}, 32'(RegFile_Out), 32'h0000);
        chk({tag, "_opb"}, 32'(SR2MUX_Out), 32'h0000);
        chk({tag, "_cnt"}, 32'(op_count), 32'h0000);
    endtask

    initial begin
        logic [1:0] exp_oh;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_aluk  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 2'b00;

        #1;
        chk_reset_vals("rst0");
        @(negedge clk);
        rst_n = 1'b1;

        do_op(0, ADD,  16'h7FFF, 16'h0001, 16'h8000, 3'b100, 16'd1, "add_ovf");
        do_op(1, NOT_, 16'hFFFF, 16'h0000, 16'h0000, 3'b010, 16'd2, "not_zero");
        do_op(1, AND_, 16'h00F0, 16'h0FF0, 16'h00F0, 3'b001, 16'd3, "and_pos");

        // Round-robin from a fresh reset with both requesters always asking
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst1");
        @(negedge clk);
        rst_n       = 1'b1;
        req_aluk[0] = ADD;
        req_a[0]    = 16'h0001;
        req_b[0]    = 16'h0002;
        req_aluk[1] = PASS_A;
        req_a[1]    = 16'h8001;
        req_b[1]    = 16'h5555;
        req_valid   = 2'b11;
        rsp_ready   = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_oh = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            chk("rr_grant", 32'(req_ready), 32'(exp_oh));
            @(posedge clk); @(negedge clk);
            #1;
            chk("rr_noaccept_issue", 32'(req_ready), 32'd0);
            @(posedge clk); @(negedge clk);
            #1;
            chk("rr_noaccept_resp", 32'(req_ready), 32'd0);
            chk("rr_rvld", 32'(rsp_valid), 32'(exp_oh));
            chk("rr_data", 32'(rsp_data), (i % 2 == 0) ? 32'h0003 : 32'h8001);
            chk("rr_nzp", 32'(rsp_nzp), (i % 2 == 0) ? 32'b001 : 32'b100);
            @(posedge clk); @(negedge clk);
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        #1;
        chk("rr_cnt", 32'(op_count), 32'd4);

        // Response held off for five cycles; other requester's ready must be ignored
        req_aluk[0] = ADD;
        req_a[0]    = 16'h0005;
        req_b[0]    = 16'hFFFB;
        req_valid   = 2'b01;
        #1;
        chk("hold_ready", 32'(req_ready), 32'b01);
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        @(posedge clk); @(negedge clk);
        rsp_ready = 2'b10;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("hold_vld", 32'(rsp_valid), 32'b01);
            chk("hold_data", 32'(rsp_data), 32'h0000);
            chk("hold_nzp", 32'(rsp_nzp), 32'b010);
            chk("hold_cnt", 32'(op_count), 32'd4);
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 2'b01;
        @(posedge clk); @(negedge clk);
        rsp_ready = 2'b00;
        #1;
        chk("hold_cnt_inc", 32'(op_count), 32'd5);
        chk("hold_vld_done", 32'(rsp_valid), 32'd0);
        chk("hold_idle", 32'(busy), 32'd0);

        // Reset while in ISSUE abandons the operation
        req_aluk[1] = AND_;
        req_a[1]    = 16'hFFFF;
        req_b[1]    = 16'h1234;
        req_valid   = 2'b10;
        #1;
        chk("abort_ready", 32'(req_ready), 32'b10);
        @(posedge clk); @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk("abort_in_issue", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort_rst");
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
            @(posedge clk); @(negedge clk);
        end
        rsp_ready = 2'b00;

        // Counter wrap: preload all-ones, then complete one operation
        force dut.cnt_q = 16'hFFFF;
        #1;
        release dut.cnt_q;
        chk("wrap_pre", 32'(op_count), 32'hFFFF);
        do_op(0, AND_, 16'hFFFF, 16'h8000, 16'h8000, 3'b100, 16'h0000, "wrap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
